// File: rtl/product_display_driver_if.sv
// Display-driver bus: product/strobe in, segment drive, digit select and busy out.
interface product_display_driver_if;
    logic [5:0] i_product;
    logic       i_valid;
    logic [6:0] o_segments;
    logic       o_lsb_digit;
    logic       o_busy;

    modport master (
        output i_product,
        output i_valid,
        input  o_segments,
        input  o_lsb_digit,
        input  o_busy
    );

    modport slave (
        input  i_product,
        input  i_valid,
        output o_segments,
        output o_lsb_digit,
        output o_busy
    );
endinterface

// File: rtl/product_display_driver.sv
// product_display_driver: converts a 6-bit product to two BCD digits with a
// sequential double-dabble FSM and multiplexes them onto one 7-segment bus.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module product_display_driver #(
    parameter int REFRESH_DIV    = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    product_display_driver_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_LATCH   = 2'd2
    } state_t;

    localparam int               CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_ZERO = 7'h3F;
    localparam logic [6:0]       SEG_RESET = SEG_ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;

    state_t           r_state;
    state_t           w_next_state;
    logic [13:0]      r_shift;
    logic [2:0]       r_iter;
    logic [3:0]       r_tens;
    logic [3:0]       r_units;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lsb;
    logic [6:0]       r_segments;

    logic             w_busy;
    logic             w_load;
    logic             w_step;
    logic             w_latch;
    logic             w_wrap;
    logic             w_next_lsb;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg_raw;
    logic [6:0]       w_seg_drive;

    // One double-dabble iteration: +3 on any BCD nibble >= 5, then shift left.
    function automatic logic [13:0] dabble_step(input logic [13:0] s);
        logic [3:0] t;
        logic [3:0] u;
        t = s[13:10];
        u = s[9:6];
        if (t >= 4'd5) t = t + 4'd3;
        if (u >= 4'd5) u = u + 4'd3;
        return {t[2:0], u, s[5:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // FSM state register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // FSM next-state logic: six CONVERT iterations, then one LATCH cycle.
    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (bus.i_valid)      w_next_state = S_CONVERT;
            S_CONVERT: if (r_iter == 3'd5)   w_next_state = S_LATCH;
            S_LATCH:                         w_next_state = S_IDLE;
            default:                         w_next_state = S_IDLE;
        endcase
    end

    // FSM output decode; strobes arriving outside IDLE are simply not loaded.
    always_comb begin
        w_busy  = 1'b0;
        w_load  = 1'b0;
        w_step  = 1'b0;
        w_latch = 1'b0;
        case (r_state)
            S_IDLE:    w_load = bus.i_valid;
            S_CONVERT: begin w_busy = 1'b1; w_step  = 1'b1; end
            S_LATCH:   begin w_busy = 1'b1; w_latch = 1'b1; end
            default:   ;
        endcase
    end

    // Conversion datapath: load the binary value, then iterate double-dabble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_iter  <= '0;
        end else if (w_load) begin
            r_shift <= {8'h00, bus.i_product};
            r_iter  <= '0;
        end else if (w_step) begin
            r_shift <= dabble_step(r_shift);
            r_iter  <= r_iter + 3'd1;
        end
    end

    // Display registers hold the previous value until the conversion completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tens  <= '0;
            r_units <= '0;
        end else if (w_latch) begin
            r_tens  <= r_shift[13:10];
            r_units <= r_shift[9:6];
        end
    end

    assign w_wrap     = (r_cnt == CNT_MAX);
    assign w_next_lsb = w_wrap ? ~r_lsb : r_lsb;

    // Segment source follows the post-edge digit select so bus and select agree.
    always_comb begin
        w_digit   = w_next_lsb ? r_units : r_tens;
        w_seg_raw = seg_encode(w_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (!w_next_lsb && (r_tens == 4'd0)) w_seg_raw = 7'h00;
`endif
        w_seg_drive = SEG_ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
    end

    // Free-running refresh counter, digit select and registered segment bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_lsb      <= 1'b1;
            r_segments <= SEG_RESET;
        end else begin
            r_cnt      <= w_wrap ? '0 : r_cnt + 1'b1;
            r_lsb      <= w_next_lsb;
            r_segments <= w_seg_drive;
        end
    end

    assign bus.o_segments  = r_segments;
    assign bus.o_lsb_digit = r_lsb;
    assign bus.o_busy      = w_busy;

endmodule

// File: tb/tb_product_display_driver.sv
// Self-checking bench for product_display_driver: a cycle-counting behavioural
// model (decimal arithmetic, edge indices) plus literal spot checks.
module tb_product_display_driver;

    localparam int DIV = 4;
    localparam bit SAL = 1'b0;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    product_display_driver_if bus ();

    product_display_driver #(
        .REFRESH_DIV    (DIV),
        .SEG_ACTIVE_LOW (SAL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    // Expected bus value for a displayed decimal value and digit select.
    function automatic logic [6:0] seg_of(input int val, input bit lsb);
        logic [6:0] s;
        s = lsb ? enc(val % 10) : enc(val / 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (!lsb && (val / 10 == 0)) s = 7'h00;
`endif
        return SAL ? ~s : s;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: k counts clock edges since reset release. Strobe
    // accepted at edge t updates the display at edge t+7 and is busy in between.
    int         k;
    int         latch_edge;
    int         disp_val;
    int         pend_val;
    bit         m_lsb;
    logic [6:0] m_seg;
    bit         m_busy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k          = 0;
            latch_edge = -1;
            disp_val   = 0;
            pend_val   = 0;
            m_lsb      = 1'b1;
            m_seg      = seg_of(0, 1'b1);
            m_busy     = 1'b0;
        end else begin
            k++;
            m_lsb = ((k / DIV) % 2) == 0;
            m_seg = seg_of(disp_val, m_lsb);
            if (k == latch_edge) disp_val = pend_val;
            if (bus.i_valid && k > latch_edge) begin
                pend_val   = int'(bus.i_product);
                latch_edge = k + 7;
            end
            m_busy = (k < latch_edge);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", bus.o_busy, m_busy);
            check("lsb_digit", bus.o_lsb_digit, m_lsb);
            check("segments", bus.o_segments, m_seg);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int v);
        bus.i_product = 6'(v);
        bus.i_valid   = 1'b1;
        tick(1);
        bus.i_valid   = 1'b0;
    endtask

    // Wait (bounded) for the requested digit phase, then check the segments.
    task automatic expect_digit(input string name, input bit lsb, input logic [6:0] exp);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * DIV + 2; i++) begin
            @(negedge clk);
            if (bus.o_lsb_digit == lsb) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: digit phase %0d never reached", name, lsb);
        end else begin
            check(name, bus.o_segments, exp);
        end
    endtask

    initial begin
        int busy_cnt;
        int t_first;
        int t_second;
        int idx;
        bit prev;
        int v;
        bus.i_product = '0;
        bus.i_valid   = 1'b0;
        #1 reset_n = 1'b0;
        cmp_en = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_segments", bus.o_segments, 7'h3F);
        check("rst_lsb", bus.o_lsb_digit, 1'b1);
        check("rst_busy", bus.o_busy, 1'b0);
        tick(2);
        reset_n = 1'b1;

        // Idle refresh: select toggles every DIV clocks.
        t_first  = -1;
        t_second = -1;
        idx      = 0;
        prev     = bus.o_lsb_digit;
        while (idx < 6 * DIV && t_second < 0) begin
            @(negedge clk);
            idx++;
            if (bus.o_lsb_digit != prev) begin
                if (t_first < 0) t_first = idx;
                else             t_second = idx;
                prev = bus.o_lsb_digit;
            end
        end
        check("refresh_period", 8'(t_second - t_first), 8'(DIV));

        // 42: busy spans edges E0..E7 (seven clock periods), then 4 / 2 shown.
        tick(1);
        strobe(42);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_busy) busy_cnt++;
        end
        check("busy_len", 8'(busy_cnt), 8'd7);
        expect_digit("u42", 1'b1, 7'h5B);
        expect_digit("t42", 1'b0, 7'h66);

        // 63 and 7 (leading-zero case).
        tick(1);
        strobe(63);
        tick(9);
        expect_digit("u63", 1'b1, 7'h4F);
        expect_digit("t63", 1'b0, 7'h7D);
        tick(1);
        strobe(7);
        tick(9);
        expect_digit("u07", 1'b1, 7'h07);
`ifdef LEADING_ZERO_BLANK_EN
        expect_digit("t07", 1'b0, 7'h00);
`else
        expect_digit("t07", 1'b0, 7'h3F);
`endif

        // Strobe during busy is dropped; one after busy is accepted.
        tick(1);
        strobe(42);
        tick(2);
        strobe(9);
        tick(8);
        expect_digit("drop_u", 1'b1, 7'h5B);
        expect_digit("drop_t", 1'b0, 7'h66);
        tick(1);
        strobe(9);
        tick(9);
        expect_digit("u09", 1'b1, 7'h6F);
`ifdef LEADING_ZERO_BLANK_EN
        expect_digit("t09", 1'b0, 7'h00);
`else
        expect_digit("t09", 1'b0, 7'h3F);
`endif

        // Reset mid-conversion at E3 clears the display to 00.
        tick(1);
        strobe(49);
        tick(2);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.o_busy, 1'b0);
        check("abort_lsb", bus.o_lsb_digit, 1'b1);
        check("abort_seg", bus.o_segments, 7'h3F);
        tick(2);
        reset_n = 1'b1;
        expect_digit("abort_u", 1'b1, 7'h3F);
`ifdef LEADING_ZERO_BLANK_EN
        expect_digit("abort_t", 1'b0, 7'h00);
`else
        expect_digit("abort_t", 1'b0, 7'h3F);
`endif
        tick(1);
        strobe(49);
        tick(9);
        expect_digit("u49", 1'b1, 7'h6F);
        expect_digit("t49", 1'b0, 7'h66);

        // Randomized strobes, gaps and occasional resets against the model.
        tick(1);
        for (int i = 0; i < 80; i++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(50, 63))
                                             : int'($urandom_range(0, 63));
            strobe(v);
            tick(int'($urandom_range(0, 10)));
            if ($urandom_range(0, 19) == 0) begin
                reset_n = 1'b0;
                tick(int'($urandom_range(1, 3)));
                reset_n = 1'b1;
            end
        end
        tick(20);
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
